// File: rtl/evacuate_and_depressurize.sv
// Airlock evacuation controller: accepts an evacuate request on a sealed, pressurized
// chamber, runs a timed pump-down, then reports Evacuated until air is readmitted.
module evacuate_and_depressurize #(
    parameter int EVAC_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             begin_Evac,
    input  logic             InnerClosed,
    input  logic             OuterClosed,
    input  logic             Pressurized,
    input  logic             FandP,
    output logic             Evacuate,
    output logic             Evacuated,
    output logic             Busy,
    output logic             Fault,
    output logic [CNT_W-1:0] Remaining
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAC  = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LOAD_COUNT = CNT_W'(EVAC_CYCLES - 1);

    state_t           state, stateNext;
    logic [CNT_W-1:0] count, countNext;
    logic             sealed;

    // begin_Evac is a level request with no handshake: it is acted on only in IDLE, and a
    // FAULT is left only once the operator has dropped it.
    assign sealed = InnerClosed & OuterClosed & ~FandP;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    always_comb begin
        stateNext = state;
        countNext = count;
        unique case (state)
            IDLE: begin
                countNext = '0;
                if (begin_Evac && sealed && Pressurized) begin
                    stateNext = EVAC;
                    countNext = LOAD_COUNT;
                end
            end
            EVAC: begin
                // Losing the seal outranks completion in the same cycle.
                if (!sealed) begin
                    stateNext = FAULT;
                    countNext = '0;
                end else if (count == '0) begin
                    stateNext = DONE;
                end else begin
                    countNext = count - 1'b1;
                end
            end
            DONE: begin
                countNext = '0;
                if (!InnerClosed || FandP) begin
                    stateNext = IDLE;
                end
            end
            FAULT: begin
                countNext = '0;
                if (!begin_Evac && InnerClosed && OuterClosed) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                countNext = '0;
            end
        endcase
    end

    assign Evacuate   = (state == EVAC);
    assign Busy       = (state == EVAC);
    assign Evacuated  = (state == DONE);
    assign Fault      = (state == FAULT);
    assign Remaining  = (state == EVAC) ? count : '0;

endmodule
